// File: rtl/dot_bus_arbiter.sv
// Round-robin owner arbiter for a shared open-drain (wired-AND) line with turnaround gaps and a hold limit.
// Optional foreign-driver detection is built when DOTBUS_CONFLICT_CHK_EN is defined.
module dot_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     bus_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [N_REQ-1:0]         drive_en_o,
    output logic [$clog2(N_REQ)-1:0] owner_o,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic                     conflict_o
);

    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [TW-1:0]     turn_q, turn_d;
    logic [OW-1:0]     rr_q, rr_d;
    logic [N_REQ-1:0]  mask_q, mask_d;
    logic              timeout_q, timeout_d;
    logic              conflict_q, conflict_d;

    logic [N_REQ-1:0]  req_ok;
    logic [N_REQ-1:0]  elig;
    logic [OW:0]       pick;

    // First eligible index at or after ptr, wrapping; MSB of the result flags a winner.
    function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] el, input logic [OW-1:0] ptr);
        logic [OW:0]   res;
        logic [OW-1:0] ix;
        int            idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            ix = OW'(idx);
            if (el[ix]) res = {1'b1, ix};
        end
        return res;
    endfunction

    // Unknown request levels never count as a request.
    always_comb begin
        req_ok = '0;
        for (int i = 0; i < N_REQ; i++) req_ok[i] = (req_i[i] === 1'b1);
    end

    assign elig = req_ok & ~mask_q;
    assign pick = rr_pick(elig, rr_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        rr_d      = rr_q;
        timeout_d = 1'b0;
        mask_d    = mask_q & req_ok;
        case (state_q)
            IDLE: begin
                if (pick[OW]) begin
                    state_d = HOLD;
                    grant_d = N_REQ'(1) << pick[OW-1:0];
                    owner_d = pick[OW-1:0];
                    hold_d  = HW'(1);
                end
            end
            HOLD: begin
                if (!req_ok[owner_q] || (hold_q == HW'(MAX_HOLD))) begin
                    state_d = TURN;
                    grant_d = '0;
                    hold_d  = '0;
                    turn_d  = TW'(1);
                    rr_d    = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    if (req_ok[owner_q]) begin
                        timeout_d       = 1'b1;
                        mask_d[owner_q] = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TURN: begin
                if (turn_q == TW'(TURNAROUND)) state_d = IDLE;
                else                           turn_d  = turn_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

`ifdef DOTBUS_CONFLICT_CHK_EN
    // With every enable off the line must be released; a solid low means someone else drives it.
    assign conflict_d = conflict_q | ((state_q != HOLD) && (grant_q == '0) && (bus_i === 1'b0));
`else
    logic unused_bus;
    assign unused_bus = bus_i;
    assign conflict_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            hold_q     <= '0;
            turn_q     <= '0;
            rr_q       <= '0;
            mask_q     <= '0;
            timeout_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
            rr_q       <= rr_d;
            mask_q     <= mask_d;
            timeout_q  <= timeout_d;
            conflict_q <= conflict_d;
        end
    end

    // Grant is cleared on release, so the enables float the line through TURN and IDLE.
    assign grant_o    = grant_q;
    assign drive_en_o = grant_q;
    assign owner_o    = owner_q;
    assign busy_o     = |grant_q;
    assign timeout_o  = timeout_q;
    assign conflict_o = conflict_q;

endmodule

// File: tb/tb_dot_bus_arbiter.sv
// Bench for dot_bus_arbiter: per-cycle vector tables through a scoreboard queue, plus an async-reset sequence.
module tb_dot_bus_arbiter;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       bus;
        logic [3:0] grant;
        logic [1:0] owner;
        bit         busy;
        bit         to;
        bit         cf;
    } vec_t;

`ifdef DOTBUS_CONFLICT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       bus = 1'b1;
    logic [3:0] grant_o, drive_en_o;
    logic [1:0] owner_o;
    logic       busy_o, timeout_o, conflict_o;

    int   total = 0;
    int   bad = 0;
    int   vec_no = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    dot_bus_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .bus_i(bus),
        .grant_o(grant_o), .drive_en_o(drive_en_o), .owner_o(owner_o),
        .busy_o(busy_o), .timeout_o(timeout_o), .conflict_o(conflict_o)
    );

    always #5 clk = ~clk;

    task automatic add(input bit rst, input logic [3:0] rq, input logic bs,
                       input logic [3:0] g, input int own, input bit to, input bit cf);
        vec_t v;
        v.rst = rst; v.req = rq; v.bus = bs; v.grant = g;
        v.owner = 2'(own); v.busy = (g != 4'b0000); v.to = to; v.cf = cf;
        vecs.push_back(v);
    endtask

    task automatic add_rst();
        add(1'b1, 4'b0000, 1'b1, 4'b0000, 0, 1'b0, 1'b0);
    endtask

    task automatic check_out();
        vec_t e;
        bit   ok;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        ok = (grant_o === e.grant) && (drive_en_o === e.grant) && (busy_o === e.busy) &&
             (timeout_o === e.to) && (conflict_o === e.cf) && $onehot0(grant_o) &&
             (!(e.busy || e.rst) || (owner_o === e.owner));
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL vec%0d: got grant=%b en=%b owner=%0d busy=%b to=%b cf=%b, want grant=%b owner=%0d busy=%b to=%b cf=%b",
                     vec_no, grant_o, drive_en_o, owner_o, busy_o, timeout_o, conflict_o,
                     e.grant, e.owner, e.busy, e.to, e.cf);
        end
        vec_no++;
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst_n = !v.rst;
        req   = v.req;
        bus   = v.bus;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        logic [3:0] g;

        // Single requester: 1-clock grant latency, release, one turnaround cycle.
        add_rst();
        add(0, 4'b0001, 1, 4'b0001, 0, 0, 0);
        add(0, 4'b0001, 1, 4'b0001, 0, 0, 0);
        repeat (3) add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // All request; each owner drops after 3 cycles: order 0,1,2,3,0 with 2-cycle gaps.
        add_rst();
        for (int o = 0; o < 4; o++) begin
            g = 4'b0001 << o;
            repeat (3) add(0, 4'b1111, 1, g, o, 0, 0);
            add(0, 4'b1111 & ~g, 1, 4'b0000, 0, 0, 0);
            add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        end
        add(0, 4'b1111, 1, 4'b0001, 0, 0, 0);
        repeat (2) add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // Stuck owner: 16 grant cycles, timeout pulse, then masked while req stays high.
        add_rst();
        repeat (16) add(0, 4'b0010, 1, 4'b0010, 1, 0, 0);
        add(0, 4'b0010, 1, 4'b0000, 0, 1, 0);
        repeat (3) add(0, 4'b0010, 1, 4'b0000, 0, 0, 0);

        // Masked source skipped; a 1-cycle req drop unmasks it.
        add(0, 4'b0110, 1, 4'b0100, 2, 0, 0);
        add(0, 4'b0110, 1, 4'b0100, 2, 0, 0);
        add(0, 4'b0100, 1, 4'b0100, 2, 0, 0);
        add(0, 4'b0110, 1, 4'b0100, 2, 0, 0);
        add(0, 4'b0010, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0010, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0010, 1, 4'b0010, 1, 0, 0);
        repeat (2) add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // Move rr pointer to 2, then hold src2 before an async reset.
        add_rst();
        add(0, 4'b0010, 1, 4'b0010, 1, 0, 0);
        repeat (2) add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        repeat (2) add(0, 4'b0100, 1, 4'b0100, 2, 0, 0);
        run_table();

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (grant_o !== 4'b0000 || drive_en_o !== 4'b0000 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got grant=%b en=%b busy=%b, want all 0", grant_o, drive_en_o, busy_o);
        end

        // After release the pointer is back at 0: src0 beats src2.
        add(0, 4'b0101, 1, 4'b0001, 0, 0, 0);
        repeat (2) add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // Foreign low: ignored while owned, flagged when released, sticky until reset.
        add_rst();
        add(0, 4'b0001, 1, 4'b0001, 0, 0, 0);
        add(0, 4'b0001, 0, 4'b0001, 0, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        repeat (2) add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, CHK);
        repeat (2) add(0, 4'b0000, 1, 4'b0000, 0, 0, CHK);
        add(0, 4'b0001, 1, 4'b0001, 0, 0, CHK);
        add_rst();
        run_table();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
